vga_vram_arbiter: RTL
=====================

# vga_vram_arbiter

Single-port video-RAM arbiter between the VGA scan-out path and one host requester (CPU or drawing engine). It sits between the VGA sync block (pixel tick, video-on, pixel X/Y) and the frame-buffer RAM. Display fetches take strict priority on each pixel tick; host reads and writes use the remaining memory cycles. An optional mode restricts host writes to vertical blanking to avoid tearing.

## Interface
- ADDR_W, 19, VRAM word address width (640×480 = 307200 words)
- DATA_W, 8, pixel/word width
- H_ACTIVE, 640, active pixels per line (address stride)
- V_ACTIVE, 480, active lines per frame

Ports:
- iClk  in  1  system clock; the only clock
- iNRst  in  1  reset, asynchronous, active-low
- iPixelTick  in  1  pixel tick from sync block (level; rising edge = new pixel)
- iVideoOn  in  1  active-video flag from sync block
- iPixelX  in  16  current pixel column
- iPixelY  in  16  current pixel row
- iVBlankOnly  in  1  1 = host writes granted only when iPixelY ≥ V_ACTIVE
- iHostReq  in  1  host request; held until oHostGnt
- iHostWe  in  1  1 = write, 0 = read
- iHostAddr  in  ADDR_W  host word address
- iHostWData  in  DATA_W  host write data
- oHostGnt  out  1  one-cycle acceptance pulse
- oHostRData  out  DATA_W  host read data
- oHostRValid  out  1  one-cycle read-data-valid pulse
- oMemEn  out  1  memory access strobe (registered)
- oMemWe  out  1  memory write enable (registered)
- oMemAddr  out  ADDR_W  memory address (registered)
- oMemWData  out  DATA_W  memory write data (registered)
- iMemRData  in  DATA_W  memory read data, valid the cycle after a read strobe
- oPixelData  out  DATA_W  pixel value to DAC, 0 during blanking
- oPixelValid  out  1  one-cycle pulse when oPixelData updates

## Operation
- Tick edge detect: register iPixelTick; tick_rise = iPixelTick & ~prev.
- Per cycle exactly one memory slot, decided combinationally, registered onto oMem*:
  - tick_rise & iVideoOn: display read, addr = iPixelY·H_ACTIVE + iPixelX, truncated to ADDR_W.
  - tick_rise & ~iVideoOn: no memory access; blank token enters pipeline.
  - else iHostReq & (~iHostWe | ~iVBlankOnly | iPixelY ≥ V_ACTIVE): host access; oHostGnt asserted same cycle (combinational from registered state + inputs).
  - else idle (oMemEn = 0).
- On tick_rise the host is never granted, even when no memory access occurs.
- Return pipeline: 2-stage tag {valid, src∈{DISP, BLANK, HOST_RD}} tracks each slot. Stage 1 aligns with oMem* strobe, stage 2 with iMemRData.
  - DISP: oPixelData ← iMemRData, oPixelValid pulse.
  - BLANK: oPixelData ← 0, oPixelValid pulse.
  - HOST_RD: oHostRData ← iMemRData, oHostRValid pulse.
  - Host writes produce no return.
- Host write in VBlankOnly mode during active frame: stalled (no oHostGnt), request held by host; reads never stalled by this mode.
- Mode change of iVBlankOnly takes effect the same cycle; no effect on in-flight accesses.

## Timing
- Reset (async assert, sync-safe deassert by system): all outputs 0, tick history 0, pipeline tags invalid. In-flight host reads discarded, no oHostRValid; host must reissue.
- Display latency: tick_rise in cycle T → oMemEn at T+1 → iMemRData at T+2 → oPixelData/oPixelValid at T+3. Blank token follows the same T+3 timing.
- Host read latency: oHostGnt in cycle G → oMemEn at G+1 → oHostRValid at G+3.
- Host write: oHostGnt in G → oMemEn/oMemWe at G+1.
- Minimum pixel tick period 4 cycles (as generated by the sync block). Host therefore receives ≥3 of every 4 cycles during active video and every cycle except tick_rise during blanking.
- Back-to-back host accesses allowed every cycle; the pipeline holds up to 2 outstanding returns.
- iHostReq with tick_rise in the same cycle: display wins, host granted next eligible cycle.

## Structure
- Shared package vga_pkg: H_ACTIVE, V_ACTIVE, default ADDR_W/DATA_W, and the slot-source enum {SRC_NONE, SRC_DISP, SRC_BLANK, SRC_HOST_RD}. The VGA sync timing constants move here too.
- One sub-module: vga_addr_gen, the combinational Y·H_ACTIVE + X with width truncation. It is reusable by the drawing engine.

## Test plan
- Reset mid-read: grant a host read, assert iNRst=0 at G+2 → oHostRValid never pulses; all outputs 0 during reset.
- Display fetch: tick_rise with X=5, Y=2, iVideoOn=1 → oMemAddr=1285, oMemWe=0 at T+1; memory returns 0xA5 → oPixelData=0xA5, oPixelValid=1 at T+3.
- Blanking: tick_rise with iVideoOn=0 → oMemEn=0 at T+1; oPixelData=0, oPixelValid=1 at T+3.
- Collision: iHostReq read addr 100 asserted in tick_rise cycle → no oHostGnt in that cycle, grant next cycle; data 0x3C → oHostRValid with 0x3C three cycles after the grant.
- VBlankOnly: iVBlankOnly=1, host write while Y=100 → no grant; Y=480 → grant, oMemWe=1 with given addr/data one cycle later.
- Throughput: continuous host writes over a full line with 4-cycle ticks → exactly 3 grants per 4 cycles, no missed oPixelValid.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants and the VRAM slot-source type used by the arbiter return pipeline.
package vga_pkg;

    localparam int unsigned ADDR_W_DEF = 19;
    localparam int unsigned DATA_W_DEF = 8;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FRONT  = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BACK   = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FRONT  = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_DISP,
        SRC_BLANK,
        SRC_HOST_RD
    } src_e;

endpackage

// File: rtl/vga_addr_gen.sv
// Frame-buffer word address from pixel coordinates: y * H_ACTIVE + x, wrapped to ADDR_W bits.
module vga_addr_gen #(
    parameter int unsigned ADDR_W   = vga_pkg::ADDR_W_DEF,
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE
) (
    input  logic [15:0]       x_i,
    input  logic [15:0]       y_i,
    output logic [ADDR_W-1:0] addr_o
);

    // Doing the arithmetic at ADDR_W gives the same result as truncating a full-width sum.
    assign addr_o = ADDR_W'(y_i) * ADDR_W'(H_ACTIVE) + ADDR_W'(x_i);

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display fetch wins on each pixel-tick rise, host uses the other slots.
module vga_vram_arbiter #(
    parameter int unsigned ADDR_W   = vga_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W   = vga_pkg::DATA_W_DEF,
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE
) (
    input  logic              iClk,
    input  logic              iNRst,
    input  logic              iPixelTick,
    input  logic              iVideoOn,
    input  logic [15:0]       iPixelX,
    input  logic [15:0]       iPixelY,
    input  logic              iVBlankOnly,
    input  logic              iHostReq,
    input  logic              iHostWe,
    input  logic [ADDR_W-1:0] iHostAddr,
    input  logic [DATA_W-1:0] iHostWData,
    output logic              oHostGnt,
    output logic [DATA_W-1:0] oHostRData,
    output logic              oHostRValid,
    output logic              oMemEn,
    output logic              oMemWe,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    input  logic [DATA_W-1:0] iMemRData,
    output logic [DATA_W-1:0] oPixelData,
    output logic              oPixelValid
);

    import vga_pkg::*;

    logic              tick_q;
    logic              tick_rise;
    logic              host_ok;
    logic              slot_disp;
    logic              slot_blank;
    logic              slot_host;
    logic [ADDR_W-1:0] disp_addr;

    logic              mem_en_d,    mem_en_q;
    logic              mem_we_d,    mem_we_q;
    logic [ADDR_W-1:0] mem_addr_d,  mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
    src_e              src1_d,      src1_q;
    src_e              src2_q;

    logic              pix_valid_d,   pix_valid_q;
    logic [DATA_W-1:0] pix_data_d,    pix_data_q;
    logic              host_rvalid_d, host_rvalid_q;
    logic [DATA_W-1:0] host_rdata_d,  host_rdata_q;

    vga_addr_gen #(
        .ADDR_W  (ADDR_W),
        .H_ACTIVE(H_ACTIVE)
    ) u_addr_gen (
        .x_i   (iPixelX),
        .y_i   (iPixelY),
        .addr_o(disp_addr)
    );

    // Slot decision: exactly one owner per cycle, registered onto the memory port.
    always_comb begin
        tick_rise  = iPixelTick & ~tick_q;
        host_ok    = iHostReq & (~iHostWe | ~iVBlankOnly | (iPixelY >= 16'(V_ACTIVE)));
        slot_disp  = tick_rise & iVideoOn;
        slot_blank = tick_rise & ~iVideoOn;
        slot_host  = ~tick_rise & host_ok;

        mem_en_d    = slot_disp | slot_host;
        mem_we_d    = slot_host & iHostWe;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        src1_d      = SRC_NONE;

        if (slot_disp) begin
            mem_addr_d = disp_addr;
            src1_d     = SRC_DISP;
        end else if (slot_blank) begin
            src1_d = SRC_BLANK;
        end else if (slot_host) begin
            mem_addr_d = iHostAddr;
            if (iHostWe) begin
                mem_wdata_d = iHostWData;
            end else begin
                src1_d = SRC_HOST_RD;
            end
        end
    end

    // Return stage: src2_q lines up with the memory read data of its slot.
    always_comb begin
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        host_rvalid_d = 1'b0;
        host_rdata_d  = host_rdata_q;
        case (src2_q)
            SRC_DISP: begin
                pix_valid_d = 1'b1;
                pix_data_d  = iMemRData;
            end
            SRC_BLANK: begin
                pix_valid_d = 1'b1;
                pix_data_d  = '0;
            end
            SRC_HOST_RD: begin
                host_rvalid_d = 1'b1;
                host_rdata_d  = iMemRData;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge iNRst) begin
        if (!iNRst) begin
            tick_q        <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            src1_q        <= SRC_NONE;
            src2_q        <= SRC_NONE;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            tick_q        <= iPixelTick;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            src1_q        <= src1_d;
            src2_q        <= src1_q;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    // Grant is held low while in reset so every output reads 0.
    assign oHostGnt    = slot_host & iNRst;
    assign oMemEn      = mem_en_q;
    assign oMemWe      = mem_we_q;
    assign oMemAddr    = mem_addr_q;
    assign oMemWData   = mem_wdata_q;
    assign oPixelData  = pix_data_q;
    assign oPixelValid = pix_valid_q;
    assign oHostRData  = host_rdata_q;
    assign oHostRValid = host_rvalid_q;

endmodule
